// File: rtl/acappella_pkg.sv
// Shared constants for the acappella SDRAM path: requester indices, SDRAM bus widths
// and the arbiter state encoding.
package acappella_pkg;

  localparam int REQ_LOAD  = 0;
  localparam int REQ_MIX   = 1;
  localparam int REQ_PITCH = 2;
  localparam int REQ_REC   = 3;
  localparam int REQ_PLAY  = 4;

  localparam int SDRAM_ADDR_W = 23;
  localparam int SDRAM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RECOVER = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set bit of req_i scanning upward from ptr_i with wrap.
// Zero latency; ptr_i must be below N.
module rr_pick #(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          vld_o,
  output logic [PW-1:0] idx_o
);

  logic [PW:0]   sum;
  logic [PW-1:0] cand;

  // Walk distances from far to near so the nearest hit is the last one written.
  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    sum   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_i} + (PW + 1)'(k);
      if (sum >= (PW + 1)'(N)) begin
        sum = sum - (PW + 1)'(N);
      end
      cand = sum[PW-1:0];
      if (req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-class round-robin arbiter sharing one SDRAMBus port; grant to sdram_read/write is 1 cycle.
// Requesters hold their level request until req_finished; one transaction outstanding at a time.
// Optional watchdog via SDRAM_ARB_WATCHDOG_EN.
module sdram_arbiter
  import acappella_pkg::*;
#(
  parameter int                 NUM_REQ    = 5,
  parameter int                 ADDR_W     = SDRAM_ADDR_W,
  parameter int                 DATA_W     = SDRAM_DATA_W,
  parameter logic [NUM_REQ-1:0] HIPRI_MASK = 5'b01000,
  parameter int                 TIMEOUT    = 1024
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_REQ-1:0]          req_read,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
  output logic [DATA_W-1:0]           req_readdata,
  output logic [NUM_REQ-1:0]          req_finished,
  output logic                        sdram_read,
  output logic                        sdram_write,
  output logic [ADDR_W-1:0]           sdram_addr,
  output logic [DATA_W-1:0]           sdram_writedata,
  input  logic [DATA_W-1:0]           sdram_readdata,
  input  logic                        sdram_finished,
  output logic [2:0]                  grant_id,
`ifdef SDRAM_ARB_WATCHDOG_EN
  output logic                        arb_timeout,
`endif
  output logic                        busy
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req_v;
  logic [NUM_REQ-1:0] hi_req;
  logic [NUM_REQ-1:0] lo_req;
  logic               hi_vld;
  logic               lo_vld;
  logic [IW-1:0]      hi_idx;
  logic [IW-1:0]      lo_idx;
  logic [IW-1:0]      win;
  logic [IW-1:0]      nxt_ptr;

  logic [ADDR_W-1:0]  addr_a  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_a [NUM_REQ];

  arb_state_t         state_q;
  logic [IW-1:0]      rr_hi_q;
  logic [IW-1:0]      rr_lo_q;
  logic [IW-1:0]      gnt_q;
  logic               rd_q;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [NUM_REQ-1:0] fin_q;
  logic               busy_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = req_writedata[g*DATA_W +: DATA_W];
  end

  assign req_v  = req_read | req_write;
  assign hi_req = req_v & HIPRI_MASK;
  assign lo_req = req_v & ~HIPRI_MASK;

  rr_pick #(.N(NUM_REQ), .PW(IW)) u_pick_hi (
    .req_i (hi_req),
    .ptr_i (rr_hi_q),
    .vld_o (hi_vld),
    .idx_o (hi_idx)
  );

  rr_pick #(.N(NUM_REQ), .PW(IW)) u_pick_lo (
    .req_i (lo_req),
    .ptr_i (rr_lo_q),
    .vld_o (lo_vld),
    .idx_o (lo_idx)
  );

  always_comb begin
    win     = hi_vld ? hi_idx : lo_idx;
    nxt_ptr = (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
  end

`ifdef SDRAM_ARB_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_q;
  logic          tmo_q;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      rr_hi_q <= '0;
      rr_lo_q <= '0;
      gnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fin_q   <= '0;
      busy_q  <= 1'b0;
`ifdef SDRAM_ARB_WATCHDOG_EN
      wd_q    <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      fin_q <= '0;
      case (state_q)
        IDLE: begin
          if (hi_vld || lo_vld) begin
            gnt_q   <= win;
            addr_q  <= addr_a[win];
            wdata_q <= wdata_a[win];
            // Write wins when a requester raises both.
            wr_q    <= req_write[win];
            rd_q    <= ~req_write[win];
            busy_q  <= 1'b1;
            if (hi_vld) begin
              rr_hi_q <= nxt_ptr;
            end else begin
              rr_lo_q <= nxt_ptr;
            end
`ifdef SDRAM_ARB_WATCHDOG_EN
            wd_q    <= '0;
`endif
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (sdram_finished) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            if (rd_q) begin
              rdata_q <= sdram_readdata;
            end
            fin_q   <= NUM_REQ'(1) << gnt_q;
            state_q <= RECOVER;
          end
`ifdef SDRAM_ARB_WATCHDOG_EN
          else if (wd_q == WW'(TIMEOUT - 1)) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            fin_q   <= NUM_REQ'(1) << gnt_q;
            tmo_q   <= 1'b1;
            state_q <= RECOVER;
          end else begin
            wd_q <= wd_q + WW'(1);
          end
`endif
        end
        RECOVER: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sdram_read      = rd_q;
  assign sdram_write     = wr_q;
  assign sdram_addr      = addr_q;
  assign sdram_writedata = wdata_q;
  assign req_readdata    = rdata_q;
  assign req_finished    = fin_q;
  assign grant_id        = 3'(gnt_q);
  assign busy            = busy_q;
`ifdef SDRAM_ARB_WATCHDOG_EN
  assign arb_timeout     = tmo_q;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: vector table, hand-written corner sequences and a randomized
// scoreboard run against a queue-based arbitration model with a latency-programmable SDRAM responder.
module tb_sdram_arbiter;

  localparam int NR = 5;
  localparam int AW = 23;
  localparam int DW = 32;

  logic              i_clk;
  logic              i_rst;
  logic [NR-1:0]     req_read;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_writedata;
  logic [DW-1:0]     req_readdata;
  logic [NR-1:0]     req_finished;
  logic              sdram_read;
  logic              sdram_write;
  logic [AW-1:0]     sdram_addr;
  logic [DW-1:0]     sdram_writedata;
  logic [DW-1:0]     sdram_readdata;
  logic              sdram_finished;
  logic [2:0]        grant_id;
  logic              busy;
`ifdef SDRAM_ARB_WATCHDOG_EN
  logic              arb_timeout;
`endif

  sdram_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .HIPRI_MASK (5'b01000),
`ifdef SDRAM_ARB_WATCHDOG_EN
    .TIMEOUT    (16)
`else
    .TIMEOUT    (1024)
`endif
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .req_read        (req_read),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_writedata   (req_writedata),
    .req_readdata    (req_readdata),
    .req_finished    (req_finished),
    .sdram_read      (sdram_read),
    .sdram_write     (sdram_write),
    .sdram_addr      (sdram_addr),
    .sdram_writedata (sdram_writedata),
    .sdram_readdata  (sdram_readdata),
    .sdram_finished  (sdram_finished),
    .grant_id        (grant_id),
`ifdef SDRAM_ARB_WATCHDOG_EN
    .arb_timeout     (arb_timeout),
`endif
    .busy            (busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] fmem(input logic [AW-1:0] a);
    return 32'hDEADBEEF ^ {9'd0, a ^ 23'h000100};
  endfunction

  function automatic logic [AW-1:0] base_addr(input int i);
    return AW'((i + 1) * 128);
  endfunction

  function automatic logic [DW-1:0] base_data(input int i);
    return 32'hA5A50000 | DW'(i * 32'h1111);
  endfunction

  // SDRAM responder: finishes in the lat-th active cycle, records what it saw.
  int              lat   = 5;
  bit              hang  = 0;
  bit              stray = 0;
  int              rcnt  = 0;
  logic [AW-1:0]   st_addr;
  logic [DW-1:0]   st_wd;
  logic            st_w, st_r, st_ok;
  logic [AW-1:0]   last_addr;
  logic [DW-1:0]   last_wd;
  logic            last_w, last_r, last_ok;
  int              last_act;

  initial begin
    sdram_finished = 1'b0;
    sdram_readdata = '0;
    forever begin
      @(negedge i_clk);
      sdram_finished = 1'b0;
      if ((sdram_read || sdram_write) && !i_rst) begin
        if (rcnt == 0) begin
          st_addr = sdram_addr; st_wd = sdram_writedata;
          st_w = sdram_write; st_r = sdram_read; st_ok = 1'b1;
        end else if (sdram_addr !== st_addr || sdram_writedata !== st_wd ||
                     sdram_write !== st_w || sdram_read !== st_r) begin
          st_ok = 1'b0;
        end
        rcnt++;
        if (!hang && rcnt >= lat) begin
          sdram_finished = 1'b1;
          sdram_readdata = fmem(sdram_addr);
          last_addr = st_addr; last_wd = st_wd; last_w = st_w; last_r = st_r;
          last_ok = st_ok; last_act = rcnt;
          rcnt = 0;
        end
      end else begin
        rcnt = 0;
        sdram_finished = stray;
      end
    end
  end

  task automatic set_bus();
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]      = base_addr(i);
      req_writedata[i*DW +: DW] = base_data(i);
    end
  endtask

  logic [DW-1:0] exp_rd;

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1; req_read = '0; req_write = '0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    exp_rd = '0;
  endtask

  task automatic wait_done(input string nm, output logic [NR-1:0] fin, output bit ok);
    ok = 1'b0; fin = '0;
    for (int c = 0; c < 80; c++) begin
      @(negedge i_clk);
      if (req_finished != '0) begin
        fin = req_finished; ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s: no finished pulse within 80 cycles", nm);
    end
  endtask

  // Checks the just-finished transaction against requester gid's bus values.
  task automatic chk_txn(input string nm, input logic [NR-1:0] fin, input int gid, input bit is_w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk({nm, ".fin"}, 64'(fin), 64'(NR'(1) << gid));
    chk({nm, ".gid"}, 64'(grant_id), 64'(gid));
    chk({nm, ".op"}, {62'd0, last_w, last_r}, {62'd0, is_w, ~is_w});
    chk({nm, ".addr"}, 64'(last_addr), 64'(a));
    if (is_w) chk({nm, ".wdata"}, 64'(last_wd), 64'(d));
    else      exp_rd = fmem(a);
    chk({nm, ".rdata"}, 64'(req_readdata), 64'(exp_rd));
    chk({nm, ".stable"}, 64'(last_ok), 64'd1);
  endtask

  typedef struct {
    logic [NR-1:0] rd;
    logic [NR-1:0] wr;
    int            lat;
    int            gid;
    bit            is_w;
  } vec_t;

  typedef struct {
    logic [1:0]    op;   // 0 read, 1 write, 2 read+write
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } rt_t;

  rt_t tr [NR][8];
  int  nt [NR];
  int  hd [NR];

  task automatic present();
    for (int i = 0; i < NR; i++) begin
      if (hd[i] < nt[i]) begin
        req_read[i]               = (tr[i][hd[i]].op != 2'd1);
        req_write[i]              = (tr[i][hd[i]].op != 2'd0);
        req_addr[i*AW +: AW]      = tr[i][hd[i]].a;
        req_writedata[i*DW +: DW] = tr[i][hd[i]].d;
      end else begin
        req_read[i]  = 1'b0;
        req_write[i] = 1'b0;
      end
    end
  endtask

  initial begin
    vec_t          tv [10];
    logic [NR-1:0] fin;
    logic [NR-1:0] him;
    bit            ok;
    int            cnt;
    int            expq [$];

    him = 5'b01000;
    // Pointer evolution from reset: lo 0->2->3->0, hi 0->4, lo 0->3->1->2->0.
    tv[0] = '{5'b00010, 5'b00000, 5, 1, 1'b0};
    tv[1] = '{5'b00000, 5'b00111, 2, 2, 1'b1};
    tv[2] = '{5'b10001, 5'b00000, 1, 4, 1'b0};
    tv[3] = '{5'b11000, 5'b00000, 3, 3, 1'b0};
    tv[4] = '{5'b00000, 5'b01001, 4, 3, 1'b1};
    tv[5] = '{5'b00100, 5'b00100, 2, 2, 1'b1};
    tv[6] = '{5'b00011, 5'b00000, 6, 0, 1'b0};
    tv[7] = '{5'b11111, 5'b00000, 1, 3, 1'b0};
    tv[8] = '{5'b10111, 5'b00000, 3, 1, 1'b0};
    tv[9] = '{5'b00000, 5'b10001, 2, 4, 1'b1};

    i_rst = 1'b1; req_read = '0; req_write = '0; exp_rd = '0;
    set_bus();
    @(negedge i_clk);
    chk("rst.read",  64'(sdram_read), 64'd0);
    chk("rst.write", 64'(sdram_write), 64'd0);
    chk("rst.fin",   64'(req_finished), 64'd0);
    chk("rst.gid",   64'(grant_id), 64'd0);
    chk("rst.busy",  64'(busy), 64'd0);
    chk("rst.rdata", 64'(req_readdata), 64'd0);
    chk("rst.addr",  64'(sdram_addr), 64'd0);
    chk("rst.wdata", 64'(sdram_writedata), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    for (int e = 0; e < 10; e++) begin
      @(negedge i_clk);
      lat = tv[e].lat;
      req_read = tv[e].rd; req_write = tv[e].wr;
      wait_done($sformatf("vec%0d", e), fin, ok);
      req_read = '0; req_write = '0;
      if (ok) begin
        chk_txn($sformatf("vec%0d", e), fin, tv[e].gid, tv[e].is_w,
                base_addr(tv[e].gid), base_data(tv[e].gid));
        chk($sformatf("vec%0d.lat", e), 64'(last_act), 64'(tv[e].lat));
        chk($sformatf("vec%0d.busy", e), 64'(busy), 64'd1);
      end
      @(negedge i_clk);
      chk($sformatf("vec%0d.pulse1", e), 64'(req_finished), 64'd0);
      @(negedge i_clk);
      @(negedge i_clk);
      chk($sformatf("vec%0d.idle", e), {62'd0, busy, sdram_read | sdram_write}, 64'd0);
    end

    // Stray sdram_finished while idle.
    @(negedge i_clk); stray = 1'b1;
    @(negedge i_clk); stray = 1'b0;
    @(negedge i_clk);
    chk("stray", {57'd0, req_finished, busy, sdram_read}, 64'd0);

    // Low-priority round robin with 0,1,2 holding writes.
    do_reset();
    lat = 2; req_write = 5'b00111;
    for (int n = 0; n < 6; n++) begin
      wait_done("rr", fin, ok);
      if (ok) chk_txn($sformatf("rr%0d", n), fin, n % 3, 1'b1, base_addr(n % 3), base_data(n % 3));
      if (n == 5) req_write = '0;
      @(negedge i_clk);
      chk($sformatf("rr%0d.pulse1", n), 64'(req_finished), 64'd0);
    end

    // Priority: 3 (high) starves 4 (low) while held.
    do_reset();
    @(negedge i_clk);
    lat = 3; req_read = 5'b11000;
    for (int n = 0; n < 5; n++) begin
      wait_done("pri", fin, ok);
      if (ok) chk_txn($sformatf("pri%0d", n), fin, (n < 4) ? 3 : 4, 1'b0,
                      base_addr((n < 4) ? 3 : 4), base_data(0));
      if (n == 3) req_read[3] = 1'b0;
      if (n == 4) req_read = '0;
    end

    // Requester 2 drops its write after one cycle in ISSUE.
    @(negedge i_clk);
    lat = 4; req_write = 5'b00100;
    @(negedge i_clk);
    chk("drop.issue", 64'(sdram_write), 64'd1);
    req_write = '0;
    wait_done("drop", fin, ok);
    if (ok) chk_txn("drop", fin, 2, 1'b1, base_addr(2), base_data(2));
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      if (sdram_read || sdram_write || req_finished != '0) cnt++;
    end
    chk("drop.noretry", 64'(cnt), 64'd0);

    // Async reset during ISSUE.
    hang = 1'b1; req_read = 5'b00001;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("arst.issue", 64'(sdram_read), 64'd1);
    #2 i_rst = 1'b1;
    #1;
    chk("arst.drop", {58'd0, req_finished, sdram_read | sdram_write}, 64'd0);
    chk("arst.busy", 64'(busy), 64'd0);
    chk("arst.gid",  64'(grant_id), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0; hang = 1'b0; lat = 2; exp_rd = '0;
    @(negedge i_clk);
    chk("arst.regrant", {61'd0, grant_id, sdram_read}, {61'd0, 3'd0, 1'b1});
    wait_done("arst", fin, ok);
    req_read = '0;
    if (ok) chk_txn("arst", fin, 0, 1'b0, base_addr(0), base_data(0));

`ifdef SDRAM_ARB_WATCHDOG_EN
    @(negedge i_clk);
    @(negedge i_clk);
    hang = 1'b1; req_read = 5'b00010; cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge i_clk);
      if (sdram_read) cnt++;
      if (req_finished != '0) break;
    end
    req_read = '0;
    chk("wd.cycles", 64'(cnt), 64'd16);
    chk("wd.fin",    64'(req_finished), 64'b00010);
    chk("wd.rdata",  64'(req_readdata), 64'd0);
    hang = 1'b0;
    repeat (4) @(negedge i_clk);
    chk("wd.sticky", 64'(arb_timeout), 64'd1);
`endif

    // Randomized scoreboard rounds.
    for (int r = 0; r < 4; r++) begin
      int phi, plo, j, n;
      int mh [NR];
      bit anyp, anyhi;
      do_reset();
      for (int i = 0; i < NR; i++) begin
        nt[i] = int'($urandom_range(0, 6));
        hd[i] = 0; mh[i] = 0;
        for (int k = 0; k < nt[i]; k++) begin
          tr[i][k].op = 2'($urandom_range(0, 2));
          tr[i][k].a  = AW'($urandom);
          tr[i][k].d  = $urandom;
        end
      end
      expq.delete();
      phi = 0; plo = 0;
      for (int s = 0; s < 40; s++) begin
        anyp = 1'b0; anyhi = 1'b0;
        for (int i = 0; i < NR; i++) begin
          if (mh[i] < nt[i]) begin
            anyp = 1'b1;
            if (him[i]) anyhi = 1'b1;
          end
        end
        if (!anyp) break;
        j = -1;
        for (int k = 0; k < NR; k++) begin
          int c;
          c = ((anyhi ? phi : plo) + k) % NR;
          if (j < 0 && mh[c] < nt[c] && him[c] == anyhi) j = c;
        end
        if (anyhi) phi = (j + 1) % NR;
        else       plo = (j + 1) % NR;
        expq.push_back(j);
        mh[j]++;
      end
      lat = int'($urandom_range(1, 6));
      present();
      n = 0;
      for (int c = 0; c < 3000 && n < expq.size(); c++) begin
        @(negedge i_clk);
        if (req_finished != '0) begin
          j = expq[n];
          chk_txn($sformatf("rnd%0d.%0d", r, n), req_finished, j, tr[j][hd[j]].op != 2'd0,
                  tr[j][hd[j]].a, tr[j][hd[j]].d);
          hd[j]++; n++;
          lat = int'($urandom_range(1, 6));
          present();
        end
      end
      chk($sformatf("rnd%0d.count", r), 64'(n), 64'(expq.size()));
      req_read = '0; req_write = '0;
      set_bus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAMBus client port (sdram_addr/read/write/writedata/readdata/finished) among NUM_REQ requester cores: LoadCore, MixCore, PitchCore, RecordCore and PlayCore.
- Replaces the control_mode-based static mux in the top-level core, so concurrent cores (e.g. record while play) can both reach SDRAM.
- Two priority classes: high-priority requesters (audio-realtime) always win over low-priority ones; round-robin within each class. One transaction is outstanding at a time.

Parameters:
- NUM_REQ, 5, number of requesters; index 0..NUM_REQ-1.
- ADDR_W, 23, SDRAM word address width.
- DATA_W, 32, SDRAM data width.
- HIPRI_MASK, 5'b01000, bit i set = requester i is high priority (default: RecordCore, index 3).
- TIMEOUT, 1024, watchdog cycle limit (used only with the optional feature).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- req_read  in  NUM_REQ  per-requester read request, level, held until its finished pulse.
- req_write  in  NUM_REQ  per-requester write request, level, held until its finished pulse.
- req_addr  in  NUM_REQ*ADDR_W  packed per-requester address.
- req_writedata  in  NUM_REQ*DATA_W  packed per-requester write data.
- req_readdata  out  DATA_W  read data, shared by all requesters; valid when that requester's req_finished pulses.
- req_finished  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- sdram_read  out  1  to SDRAMBus.
- sdram_write  out  1  to SDRAMBus.
- sdram_addr  out  ADDR_W  to SDRAMBus.
- sdram_writedata  out  DATA_W  to SDRAMBus.
- sdram_readdata  in  DATA_W  from SDRAMBus.
- sdram_finished  in  1  from SDRAMBus, one-cycle done pulse.
- grant_id  out  3  index of the current or last granted requester (debug/LEDG).
- busy  out  1  high in ISSUE and RECOVER.

Behaviour:
- Reset (async): state=IDLE. All outputs 0. rr_hi and rr_lo round-robin pointers = 0. Latched op, addr and data = 0.
- Request vector: req_v[i] = req_read[i] | req_write[i]. If both are set for one requester, the write is serviced and the read is ignored for that transaction.
- IDLE:
  - If any high-priority request is pending, pick the first set bit of (req_v & HIPRI_MASK) scanning upward from rr_hi, with wrap. Otherwise apply the same scan to (req_v & ~HIPRI_MASK) from rr_lo.
  - On a pick: latch addr, writedata and op from the winner; set grant_id; set the winning class pointer to winner+1 mod NUM_REQ; go to ISSUE.
  - Latency from request to sdram_read/write asserted: 1 cycle (registered).
- ISSUE:
  - sdram_read/sdram_write asserted from the latched op. sdram_addr and sdram_writedata are driven from latches, stable for the whole transaction.
  - Held until sdram_finished=1.
  - On sdram_finished: deassert sdram_read/write next cycle; register sdram_readdata into req_readdata; pulse req_finished[grant] for exactly 1 cycle; go to RECOVER.
- RECOVER: one cycle so the requester can drop or advance its request; then IDLE. Each transaction costs SDRAM latency + 2 cycles of overhead.
- A requester that deasserts mid-transaction does not abort it. The transaction completes and the finished pulse still fires.
- A grant change never occurs outside IDLE. Requests arriving during ISSUE or RECOVER wait.
- sdram_finished seen in IDLE or RECOVER is ignored.
- req_readdata holds its last value between reads. It updates only on completed reads, not writes.
- Reset mid-transaction: SDRAM outputs drop to 0 immediately and no finished pulse is issued.
- Starvation bound: a low-priority requester waits indefinitely only while high-priority requests are continuously pending. Within a class, the wait is at most NUM_REQ-1 transactions.

Optional Feature:
- Macro: SDRAM_ARB_WATCHDOG_EN.
- With it: a counter runs in ISSUE. When it reaches TIMEOUT cycles without sdram_finished, the arbiter deasserts sdram_read/write, pulses req_finished[grant] with req_readdata=0, sets sticky output arb_timeout (1 bit, cleared only by reset) and goes to RECOVER.
- Without it: no counter; the arb_timeout port does not exist; ISSUE waits forever.

Decomposition:
- Shared package acappella_pkg: requester index constants (REQ_LOAD=0, REQ_MIX=1, REQ_PITCH=2, REQ_REC=3, REQ_PLAY=4), the arbiter state enum (IDLE, ISSUE, RECOVER) and SDRAM ADDR_W/DATA_W constants.
- One sub-module: rr_pick, a combinational round-robin first-set finder (inputs: request vector and pointer; outputs: valid and index). It is instantiated twice, once per priority class.

Test Plan:
- Single read: req_read[1]=1, addr=23'h000100; SDRAM model returns 32'hDEADBEEF after 5 cycles -> sdram_read high for those 5 cycles with addr 23'h000100; req_readdata=32'hDEADBEEF in the same cycle req_finished[1] pulses for 1 cycle.
- Low-priority round robin: requesters 0, 1, 2 all hold writes -> grant order 0, 1, 2, 0, 1, 2; each req_finished pulse is 1 cycle; sdram_writedata matches the granted requester.
- Priority: req 4 (low) and req 3 (high) request in the same cycle -> req 3 is served first. With req 3 re-requesting continuously, req 4 is never granted; once req 3 drops, req 4 is served next.
- Requester drops its request in ISSUE (req_write[2] low after 1 cycle) -> the transaction completes, req_finished[2] still pulses, and no second transaction is issued for req 2.
- Async reset asserted in ISSUE -> sdram_read/write and req_finished go 0 without waiting for a clock edge. After release, req 0 pending -> the arbiter is granting req 0 within 1 cycle.
- With SDRAM_ARB_WATCHDOG_EN, TIMEOUT=16: sdram_finished never arrives -> after 16 cycles, req_finished pulses with readdata 0 and arb_timeout=1 stays set.
